// File: rtl/align_grs_shifter_if.sv
// rtl/align_grs_shifter_if.sv - request/result handshake bundle for the GRS alignment shifter
interface align_grs_shifter_if #(
  parameter int N   = 25,
  parameter int SHW = 5
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;
  logic [SHW-1:0] in_shift;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_data;
  logic           out_round;
  logic           out_sticky;

  modport master (
    output in_valid, in_data, in_shift, out_ready,
    input  in_ready, out_valid, out_data, out_round, out_sticky
  );

  modport slave (
    input  in_valid, in_data, in_shift, out_ready,
    output in_ready, out_valid, out_data, out_round, out_sticky
  );
endinterface

// File: rtl/align_grs_shifter.sv
// rtl/align_grs_shifter.sv - one-bit-per-cycle right shifter producing guard/round/sticky for RNE
module align_grs_shifter #(
  parameter int N   = 25,
  parameter int SHW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  align_grs_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] SAT_SHIFT = SHW'(N + 1);

  state_t         state_q;
  logic [SHW-1:0] count_q;
  logic [N-1:0]   data_q;
  logic           round_q;
  logic           sticky_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [SHW-1:0] load_count_d;

  // Beyond N+1 positions every input bit already sits in sticky, so further steps are no-ops.
  always_comb begin
    load_count_d = bus.in_shift;
    if (bus.in_shift > SAT_SHIFT) begin
      load_count_d = SAT_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      data_q      <= '0;
      round_q     <= 1'b0;
      sticky_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.in_data;
            round_q    <= 1'b0;
            sticky_q   <= 1'b0;
            count_q    <= load_count_d;
            in_ready_q <= 1'b0;
            if (load_count_d == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          sticky_q <= sticky_q | round_q;
          round_q  <= data_q[0];
          data_q   <= data_q >> 1;
          count_q  <= count_q - SHW'(1);
          if (count_q == SHW'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = data_q;
  assign bus.out_round  = round_q;
  assign bus.out_sticky = sticky_q;

endmodule

// File: doc/align_grs_shifter.md
ALIGN_GRS_SHIFTER -- requirements
Module: align_grs_shifter

Interface
REQ-001 Parameter N, default 25, data width of the fraction being aligned.
REQ-002 Parameter SHW, default 5, width of the shift-amount input; SHW SHALL satisfy 2**SHW > N+1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream request carries valid in_data/in_shift.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_data  input  N  unsigned fraction to be right-shifted.
REQ-008 in_shift  input  SHW  unsigned right-shift amount.
REQ-009 out_valid  output  1  aligned result available.
REQ-010 out_ready  input  1  downstream (round-nearest-even stage) consumes result.
REQ-011 out_data  output  N  aligned fraction (truncated).
REQ-012 out_round  output  1  round bit: last bit shifted out.
REQ-013 out_sticky  output  1  OR of every bit shifted out before the round bit.

Function
REQ-014 The block SHALL implement FSM states IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept: on an edge in IDLE with in_valid=1, the block SHALL load data<=in_data, round<=0, sticky<=0, count<=min(in_shift, N+1).
REQ-016 After accept, next state SHALL be DONE if the loaded count is 0, else SHIFT.
REQ-017 Each edge in SHIFT SHALL perform exactly one step: sticky<=sticky|round; round<=data[0]; data<=data>>1 (zero fill); count<=count-1.
REQ-018 The SHIFT step performed with count=1 SHALL transition to DONE.
REQ-019 Latency: out_valid SHALL rise on the s-th rising edge after the accepting edge, s = min(in_shift, N+1); for s=0 it rises on the accepting edge.
REQ-020 Shift saturation: in_shift > N+1 SHALL behave identically to in_shift = N+1 (data=0, round=0, sticky=OR of all input bits).
REQ-021 in_shift = N SHALL yield data=0, round=in_data[N-1], sticky=OR(in_data[N-2:0]).
REQ-022 In DONE, out_data/out_round/out_sticky SHALL be stable until the edge where out_ready=1, which SHALL return the FSM to IDLE.
REQ-023 No overlap: a request presented while in SHIFT or DONE SHALL not be accepted and SHALL not disturb the datapath.
REQ-024 In IDLE and SHIFT, outputs SHALL reflect the internal data/round/sticky registers but carry no meaning (out_valid=0).
REQ-025 out_data, out_round, out_sticky SHALL be registered outputs with no combinational path from in_* ports.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, count=0, data=0, round=0, sticky=0, out_valid=0, in_ready=1 once released (in_ready=0 not required during reset).
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL discard the in-flight operation; no result SHALL be presented after release.
REQ-028 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (N=25, SHW=5)
REQ-029 in_data=0x0000003, in_shift=1 -> after 1 edge: out_valid=1, out_data=0x0000001, round=1, sticky=0.
REQ-030 in_data=0x000000B, in_shift=3 -> after 3 edges: out_data=0x0000001, round=0, sticky=1.
REQ-031 in_data=0x1555555, in_shift=0 -> out_valid on accepting edge, out_data=0x1555555, round=0, sticky=0.
REQ-032 in_data=0x1FFFFFF, in_shift=31 -> after 26 edges: out_data=0, round=0, sticky=1; in_shift=26 gives identical result/latency.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs unchanged, in_ready=0, new request accepted only after out_ready handshake.
REQ-034 Assert rst_n=0 at 3rd SHIFT edge of a shift-10 request -> out_valid=0 immediately, outputs 0, in_ready=1 after release, no stale result. Bench SHALL also feed out_* into the round-nearest-even stage and compare against exact shifted value rounded to nearest-even, exhaustively over in_shift for random in_data.
